// File: rtl/cbd_sampler_stream_if.sv
// ----------------------------------------------------------------------------
// cbd_sampler_stream_if
//   Coefficient stream between the CBD noise sampler and its consumer
//   (NTT / poly-add datapath). One beat carries LANES coefficients.
//
//   out_valid   producer -> consumer  beat on out_coeffs is valid
//   out_ready   consumer -> producer  consumer accepts the beat this cycle
//   out_coeffs  producer -> consumer  lane L at bits L*COEFF_W +: COEFF_W
//   out_idx     producer -> consumer  index of the coefficient in lane 0
//   out_last    producer -> consumer  final beat of the polynomial
//
//   modport master : sampler side (drives the beat, observes ready)
//   modport slave  : consumer side (observes the beat, drives ready)
// ----------------------------------------------------------------------------
interface cbd_sampler_stream_if #(
  parameter int LANES   = 4,
  parameter int COEFF_W = 16
);
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*COEFF_W-1:0] out_coeffs;
  logic [7:0]               out_idx;
  logic                     out_last;

  modport master (
    output out_valid,
    output out_coeffs,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_coeffs,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/cbd_sampler_stream.sv
// ----------------------------------------------------------------------------
// cbd_sampler_stream
//   Centred-binomial noise sampler (eta = 2 or 3). Takes one PRF output block,
//   turns it into N coefficients c = popcount(a bits) - popcount(b bits) and
//   streams them LANES per beat over a valid/ready interface. Coefficients are
//   either sign-extended two's complement or mapped into [0, Q-1].
//
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request to sample noise_in (accepted only when idle)
//   noise_in   in   PRF block, NOISE_W bits, byte 0 in the top 8 bits
//   mod_q_en   in   0: two's-complement coefficients, 1: mod-q encoding
//   busy       out  high from start acceptance through the done pulse
//   done       out  one-cycle pulse after the final beat handshake
//   strm       master modport of cbd_sampler_stream_if (coefficient beats)
// ----------------------------------------------------------------------------
module cbd_sampler_stream #(
  parameter  int ETA     = 2,
  parameter  int LANES   = 4,
  parameter  int COEFF_W = 16,
  parameter  int N       = 256,
  parameter  int Q       = 3329,
  localparam int NOISE_W = 2 * ETA * N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NOISE_W-1:0]   noise_in,
  input  logic                 mod_q_en,
  output logic                 busy,
  output logic                 done,
  cbd_sampler_stream_if.master strm
);

  localparam int BEAT_BITS = 2 * ETA * LANES;
  localparam int NBYTES    = NOISE_W / 8;
  localparam logic [7:0] LAST_IDX = 8'(N - LANES);
  localparam logic [7:0] IDX_STEP = 8'(LANES);

  // Elaboration-time parameter checks
  if (ETA != 2 && ETA != 3) begin : g_bad_eta
    $error("cbd_sampler_stream: ETA must be 2 or 3");
  end
  if ((N % LANES) != 0) begin : g_bad_lanes
    $error("cbd_sampler_stream: LANES must divide N");
  end
  if (N > 256) begin : g_bad_n
    $error("cbd_sampler_stream: N must fit the 8-bit coefficient index");
  end
  if (COEFF_W < 4) begin : g_bad_w
    $error("cbd_sampler_stream: COEFF_W must be at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [NOISE_W-1:0]   noise_reg;      // stream-ordered, current beat in the LSBs
  logic [NOISE_W-1:0]   noise_ord;      // noise_in rearranged into stream bit order
  logic                 mod_q_reg;
  logic [7:0]           idx_reg;
  logic [LANES*COEFF_W-1:0] coeffs_flat;
  logic                 accept;
  logic                 beat_fire;
  logic                 beat_last;

  genvar gi;

  // Stream bit 8j+k is bit k of byte j, and byte j sits at the top of
  // noise_in counting downwards. Flipping byte order once at capture means
  // coefficient i later lives at plain bit offset i*2*ETA.
  for (gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign noise_ord[gi*8 +: 8] = noise_in[NOISE_W-1-8*gi -: 8];
  end

  assign accept    = (state_reg == ST_IDLE) && start;
  assign beat_last = (idx_reg == LAST_IDX);
  assign beat_fire = (state_reg == ST_RUN) && strm.out_ready;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (strm.out_ready && beat_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      noise_reg <= '0;
      mod_q_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        noise_reg <= noise_ord;
        mod_q_reg <= mod_q_en;
        idx_reg   <= '0;
      end else if (beat_fire) begin
        if (beat_last) begin
          // Drop the consumed block so the idle outputs read as zero again.
          noise_reg <= '0;
          idx_reg   <= '0;
        end else begin
          // Shift the next beat's 2*ETA*LANES bits down into the lane window.
          noise_reg <= noise_reg >> BEAT_BITS;
          idx_reg   <= idx_reg + IDX_STEP;
        end
      end
    end
  end

  // Per-lane coefficient: a - b lies in [-ETA, ETA], so 4 signed bits suffice.
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic [2*ETA-1:0]   bits;
    logic [3:0]         pop_a;
    logic [3:0]         pop_b;
    logic [3:0]         diff;
    logic [COEFF_W-1:0] coeff;

    assign bits = noise_reg[gi*2*ETA +: 2*ETA];

    always_comb begin
      pop_a = '0;
      pop_b = '0;
      for (int k = 0; k < ETA; k++) begin
        pop_a = pop_a + {3'b000, bits[k]};
        pop_b = pop_b + {3'b000, bits[ETA+k]};
      end
      diff = pop_a - pop_b;
      if (mod_q_reg && diff[3]) begin
        // Q + c for negative c, done as a wrap-around add of the sign-extended value
        coeff = COEFF_W'(Q) + {{(COEFF_W-4){1'b1}}, diff};
      end else begin
        coeff = {{(COEFF_W-4){diff[3]}}, diff};
      end
    end

    assign coeffs_flat[gi*COEFF_W +: COEFF_W] = coeff;
  end

  // Outputs decode directly from registered state, so they are stable while
  // the consumer stalls (nothing shifts until a handshake).
  assign strm.out_valid  = (state_reg == ST_RUN);
  assign strm.out_last   = (state_reg == ST_RUN) && beat_last;
  assign strm.out_idx    = idx_reg;
  assign strm.out_coeffs = coeffs_flat;
  assign busy            = (state_reg != ST_IDLE);
  assign done            = (state_reg == ST_DONE);

endmodule

// File: tb/tb_cbd_sampler_stream.sv
// ----------------------------------------------------------------------------
// tb_cbd_sampler_stream
//   Bench for cbd_sampler_stream. Two instances (ETA=2 and ETA=3, LANES=4,
//   COEFF_W=16) share the stimulus; sel chooses which one is started and
//   observed. Expected beats come from a behavioural CBD model and are queued
//   when a polynomial is launched, then popped at each output handshake.
// ----------------------------------------------------------------------------
module tb_cbd_sampler_stream;

  typedef struct packed {
    logic [63:0] coeffs;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mod_q_en = 1'b0;
  logic          out_ready = 1'b0;
  logic          sel = 1'b0;
  logic [1535:0] noise_bus = '0;

  logic start2, start3;
  logic busy2, done2, busy3, done3;

  logic        o_valid, o_last, o_busy, o_done;
  logic [63:0] o_coeffs;
  logic [7:0]  o_idx;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[$];
  logic [15:0] first_c0;
  logic [63:0] or_coeffs;

  always #5 clk = ~clk;

  cbd_sampler_stream_if #(.LANES(4), .COEFF_W(16)) s2_if ();
  cbd_sampler_stream_if #(.LANES(4), .COEFF_W(16)) s3_if ();

  assign start2 = start & ~sel;
  assign start3 = start & sel;
  assign s2_if.out_ready = out_ready;
  assign s3_if.out_ready = out_ready;

  cbd_sampler_stream #(.ETA(2), .LANES(4), .COEFF_W(16), .N(256), .Q(3329)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .noise_in(noise_bus[1023:0]),
    .mod_q_en(mod_q_en), .busy(busy2), .done(done2), .strm(s2_if)
  );

  cbd_sampler_stream #(.ETA(3), .LANES(4), .COEFF_W(16), .N(256), .Q(3329)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .noise_in(noise_bus),
    .mod_q_en(mod_q_en), .busy(busy3), .done(done3), .strm(s3_if)
  );

  assign o_valid  = sel ? s3_if.out_valid  : s2_if.out_valid;
  assign o_last   = sel ? s3_if.out_last   : s2_if.out_last;
  assign o_coeffs = sel ? s3_if.out_coeffs : s2_if.out_coeffs;
  assign o_idx    = sel ? s3_if.out_idx    : s2_if.out_idx;
  assign o_busy   = sel ? busy3 : busy2;
  assign o_done   = sel ? done3 : done2;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural CBD: stream bit p = bit (p%8) of byte (p/8), byte j at the
  // top of the NOISE_W-bit block counting down.
  function automatic logic [15:0] model_coeff(input logic [1535:0] nz, input int eta,
                                              input int i, input bit mq);
    int nw = 2 * eta * 256;
    int a = 0;
    int b = 0;
    int c;
    for (int t = 0; t < 2 * eta; t++) begin
      int p = i * 2 * eta + t;
      int j = p / 8;
      int k = p % 8;
      if (nz[nw - 8 - 8 * j + k]) begin
        if (t < eta) a++;
        else b++;
      end
    end
    c = a - b;
    if (mq && c < 0) return 16'(3329 + c);
    return 16'(c);
  endfunction

  function automatic logic [1535:0] mk(input logic [7:0] b0, input int eta);
    logic [1535:0] v = '0;
    v[2 * eta * 256 - 1 -: 8] = b0;
    return v;
  endfunction

  function automatic logic [1535:0] rand_noise();
    logic [1535:0] v;
    for (int w = 0; w < 48; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at a falling edge with the selected DUT idle: queue the golden
  // beats and raise start for the next rising edge.
  task automatic launch(input logic [1535:0] nz, input bit mq);
    int eta = sel ? 3 : 2;
    beat_t bt;
    noise_bus = nz;
    mod_q_en  = mq;
    for (int k = 0; k < 64; k++) begin
      for (int l = 0; l < 4; l++) bt.coeffs[l*16 +: 16] = model_coeff(nz, eta, k * 4 + l, mq);
      bt.idx  = 8'(k * 4);
      bt.last = (k == 63);
      exp_q.push_back(bt);
    end
    start = 1'b1;
  endtask

  // Drives out_ready, checks beats against the queue, checks stall stability,
  // the done pulse and busy drop. inject_cyc pulses start with different
  // noise/mode while busy; abort_beat asserts reset when that beat is shown.
  task automatic run_poly(input bit rnd_ready, input int inject_cyc, input int abort_beat);
    int    cyc = 0;
    int    beats = 0;
    bit    finished = 0;
    bit    held_v = 0;
    bit    was_last = 0;
    beat_t held;
    beat_t cur;
    beat_t want;
    first_c0  = 'x;
    or_coeffs = '0;
    while (!finished && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inject_cyc);
      if (cyc == inject_cyc) begin
        noise_bus = rand_noise();
        mod_q_en  = ~mod_q_en;
      end
      out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      cur = '{coeffs: o_coeffs, idx: o_idx, last: o_last};
      if (cyc == 1) chk("beat0_latency", {o_valid, o_idx}, {1'b1, 8'd0});
      if (held_v) begin
        chk("stall_stable", cur, held);
        held_v = 0;
      end
      if (abort_beat >= 0 && beats == abort_beat) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {o_valid, o_busy, o_done, o_idx}, 11'd0);
        exp_q.delete();
        @(negedge clk);
        chk("abort_no_done", {o_done, o_busy}, 2'b00);
        rst_n = 1'b1;
        finished = 1;
      end else if (o_done) begin
        chk("done_after_last", {o_busy, o_valid, was_last}, 3'b101);
        if (!rnd_ready) chk("done_cycle", cyc, 65);
        @(negedge clk);
        chk("idle_after_done", {o_busy, o_done, o_valid}, 3'b000);
        finished = 1;
      end else if (o_valid) begin
        if (out_ready) begin
          chk("beat_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("beat_data", cur, want);
          end
          if (beats == 0) first_c0 = o_coeffs[15:0];
          or_coeffs = or_coeffs | o_coeffs;
          beats++;
          was_last = o_last;
        end else begin
          held   = cur;
          held_v = 1;
        end
      end
    end
    start = 1'b0;
    chk("run_finished", finished, 1'b1);
    if (abort_beat < 0) chk("queue_drained", exp_q.size(), 0);
    $display("run: eta=%0d beats=%0d cycles=%0d", sel ? 3 : 2, beats, cyc);
  endtask

  initial begin
    // Reset values on both instances
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_state", {o_busy, o_valid, o_last, o_done, o_idx, o_coeffs},
          {4'b0000, 8'd0, 64'd0});
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: zero noise, eta=2
    launch('0, 1'b0);
    run_poly(1'b0, -1, -1);
    chk("t1_all_zero", or_coeffs, 64'd0);

    // T2: eta=2 single-coefficient patterns
    launch(mk(8'h03, 2), 1'b0);
    run_poly(1'b0, -1, -1);
    chk("t2_c0_pos", first_c0, 16'h0002);
    launch(mk(8'h0C, 2), 1'b0);
    run_poly(1'b0, -1, -1);
    chk("t2_c0_neg", first_c0, 16'hFFFE);
    launch(mk(8'h0C, 2), 1'b1);
    run_poly(1'b0, -1, -1);
    chk("t2_c0_modq", first_c0, 16'h0CFF);

    // T3: eta=3 patterns
    sel = 1'b1;
    @(negedge clk);
    launch(mk(8'h07, 3), 1'b0);
    run_poly(1'b0, -1, -1);
    chk("t3_c0_pos", first_c0, 16'h0003);
    launch(mk(8'h38, 3), 1'b1);
    run_poly(1'b0, -1, -1);
    chk("t3_c0_modq", first_c0, 16'h0CFE);
    launch('1, 1'b0);
    run_poly(1'b0, -1, -1);
    chk("t3_ones_zero", or_coeffs, 64'd0);

    // T4: random noise with random backpressure on both instances
    launch(rand_noise(), 1'b1);
    run_poly(1'b1, -1, -1);
    sel = 1'b0;
    @(negedge clk);
    launch(rand_noise(), 1'b0);
    run_poly(1'b1, -1, -1);
    launch(rand_noise(), 1'b1);
    run_poly(1'b1, -1, -1);

    // T5: start while busy with different noise and mode is ignored
    launch(rand_noise(), 1'b0);
    run_poly(1'b0, 5, -1);
    sel = 1'b1;
    @(negedge clk);
    launch(rand_noise(), 1'b1);
    run_poly(1'b1, 7, -1);

    // T6: reset at beat 10, then a full polynomial
    sel = 1'b0;
    @(negedge clk);
    launch(rand_noise(), 1'b1);
    run_poly(1'b0, -1, 10);
    @(negedge clk);
    launch(rand_noise(), 1'b0);
    run_poly(1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
